// File: rtl/dtree_seq_engine.sv
// Table-driven decision-tree classifier that visits one node per clock.
// A leaf after d internal nodes gives out_valid d+2 cycles after accept; the result is held until out_ready, with in_ready low while busy.
module dtree_seq_engine #(
   parameter int NUM_FEAT  = 4,
   parameter int FEAT_W    = 8,
   parameter int CLASS_W   = 2,
   parameter int NODES     = 64,
   parameter int MAX_DEPTH = 15,
   localparam int ADDR_W = (NODES > 1) ? $clog2(NODES) : 1,
   localparam int FIDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
   localparam int DEP_W  = $clog2(MAX_DEPTH + 1),
   localparam int NODE_W = 1 + FIDX_W + FEAT_W + 2 * ADDR_W + CLASS_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [ADDR_W-1:0]          cfg_addr,
   input  logic [NODE_W-1:0]          cfg_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CLASS_W-1:0]         out_class,
   output logic [DEP_W-1:0]           out_depth,
   output logic                       out_err,
   output logic                       busy
);

   typedef struct packed {
      logic                leaf;
      logic [FIDX_W-1:0]   fidx;
      logic [FEAT_W-1:0]   thr;
      logic [ADDR_W-1:0]   left;
      logic [ADDR_W-1:0]   right;
      logic [CLASS_W-1:0]  cls;
   } node_t;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   // Cleared entries are class-0 leaves, so an empty table still answers.
   localparam logic [NODE_W-1:0] NODE_RST = {1'b1, {(NODE_W-1){1'b0}}};

   state_t                      state;
   node_t                       tbl [NODES];
   logic [NUM_FEAT*FEAT_W-1:0]  feat;
   logic [ADDR_W-1:0]           ptr;
   logic [DEP_W-1:0]            depth;

   node_t                       cur;
   logic                        ptr_ok;
   logic                        fidx_ok;
   logic                        depth_max;
   logic                        go_left;
   logic                        walk_err;
   logic                        cfg_addr_ok;
   logic [FEAT_W-1:0]           sel;

   assign in_ready = (state == IDLE) && !cfg_we;
   assign busy     = (state != IDLE);

   always_comb begin
      ptr_ok      = ({1'b0, ptr} < (ADDR_W+1)'(NODES));
      cfg_addr_ok = ({1'b0, cfg_addr} < (ADDR_W+1)'(NODES));
      cur         = ptr_ok ? tbl[ptr] : node_t'('0);
      fidx_ok     = ({1'b0, cur.fidx} < (FIDX_W+1)'(NUM_FEAT));
      depth_max   = (depth == DEP_W'(MAX_DEPTH));
      sel         = '0;
      for (int k = 0; k < NUM_FEAT; k++) begin
         if (cur.fidx == FIDX_W'(k)) sel = feat[k*FEAT_W +: FEAT_W];
      end
      // Unsigned, inclusive: a feature equal to the threshold goes left.
      go_left  = (sel <= cur.thr);
      walk_err = !ptr_ok || (!cur.leaf && (!fidx_ok || depth_max));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         feat      <= '0;
         ptr       <= '0;
         depth     <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_depth <= '0;
         out_err   <= 1'b0;
         for (int i = 0; i < NODES; i++) tbl[i] <= node_t'(NODE_RST);
      end else begin
         case (state)
            IDLE: begin
               // A table write takes the cycle; a coincident vector waits.
               if (cfg_we) begin
                  if (cfg_addr_ok) tbl[cfg_addr] <= node_t'(cfg_data);
               end else if (in_valid) begin
                  feat  <= in_feat;
                  ptr   <= '0;
                  depth <= '0;
                  state <= WALK;
               end
            end
            WALK: begin
               if (walk_err) begin
                  out_class <= '0;
                  out_depth <= depth;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (cur.leaf) begin
                  out_class <= cur.cls;
                  out_depth <= depth;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  ptr   <= go_left ? cur.left : cur.right;
                  depth <= depth + DEP_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed bench for dtree_seq_engine: stimulus pushes expected results, a monitor pops and checks them.
module tb_dtree_seq_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [24:0] cfg_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_feat = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_class;
   logic [3:0]  out_depth;
   logic        out_err;
   logic        busy;

   dtree_seq_engine dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_depth(out_depth), .out_err(out_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cls;
      int dep;
      int err;
      int lat;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_wait = 0;
   logic prev_vld = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [24:0] mk(input logic leaf, input logic [1:0] fidx,
                                       input logic [7:0] thr, input logic [5:0] l,
                                       input logic [5:0] r, input logic [1:0] c);
      return {leaf, fidx, thr, l, r, c};
   endfunction

   // Monitor: on the first cycle of each result, compare against the oldest expectation.
   always @(negedge clk) begin
      if (out_valid && !prev_vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_class", int'(out_class), e.cls);
            check("out_depth", int'(out_depth), e.dep);
            check("out_err", int'(out_err), e.err);
            check("latency", cyc - e.acc, e.lat);
         end
      end
      prev_vld = out_valid;
   end

   // Called just after a negedge; returns just after the negedge following the accept.
   task automatic send(input logic [31:0] f, input int c, input int d, input int e, input int lat);
      exp_t x;
      in_feat  = f;
      in_valid = 1'b1;
      last_wait = 0;
      #1;
      while (!in_ready && last_wait < 50) begin
         @(negedge clk);
         #1;
         last_wait++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
      end else begin
         x.cls = c; x.dep = d; x.err = e; x.lat = lat; x.acc = cyc;
         exp_q.push_back(x);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 0, 1);
   endtask

   task automatic cfg(input logic [5:0] a, input logic [24:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_class", int'(out_class), 0);
      check("rst_out_depth", int'(out_depth), 0);
      check("rst_out_err", int'(out_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 1);

      // Unconfigured table: root is a class-0 leaf.
      send(32'hFFFF_FFFF, 0, 0, 0, 2);
      wait_idle();

      cfg(6'd0, mk(1'b0, 2'd0, 8'd96, 6'd1, 6'd2, 2'd0));
      cfg(6'd1, mk(1'b1, 2'd0, 8'd0, 6'd0, 6'd0, 2'd2));
      cfg(6'd2, mk(1'b1, 2'd0, 8'd0, 6'd0, 6'd0, 2'd1));
      send({24'hFFFFFF, 8'd96}, 2, 1, 0, 3);
      wait_idle();
      send({24'h000000, 8'd97}, 1, 1, 0, 3);
      wait_idle();
      send({24'hFFFFFF, 8'd0}, 2, 1, 0, 3);
      wait_idle();
      send({24'h000000, 8'd255}, 1, 1, 0, 3);
      wait_idle();

      // Backpressure: result held for five cycles, then released.
      out_ready = 1'b0;
      send({24'h0, 8'd96}, 2, 1, 0, 3);
      begin
         int n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", int'(out_valid), 1);
         check("hold_class", int'(out_class), 2);
         check("hold_depth", int'(out_depth), 1);
         check("hold_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_valid", int'(out_valid), 0);
      check("release_busy", int'(busy), 0);
      check("release_in_ready", int'(in_ready), 1);
      send({24'h0, 8'd97}, 1, 1, 0, 3);
      check("accept_after_handshake_wait", last_wait, 0);
      wait_idle();

      // Collision: write wins and the vector is held off.
      cfg_we   = 1'b1;
      cfg_addr = 6'd0;
      cfg_data = mk(1'b1, 2'd0, 8'd0, 6'd0, 6'd0, 2'd3);
      in_feat  = 32'h0;
      in_valid = 1'b1;
      #1;
      check("collision_in_ready", int'(in_ready), 0);
      @(negedge clk);
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      check("collision_busy", int'(busy), 0);
      send(32'h0, 3, 0, 0, 2);
      wait_idle();

      // Self-loop root: depth overflow; a write during the walk is ignored.
      cfg(6'd0, mk(1'b0, 2'd1, 8'd0, 6'd0, 6'd0, 2'd0));
      send(32'h0000_0500, 0, 15, 1, 17);
      cfg(6'd0, mk(1'b1, 2'd0, 8'd0, 6'd0, 6'd0, 2'd1));
      wait_idle();
      send(32'h0000_0500, 0, 15, 1, 17);
      wait_idle();

      // Depth-4 chain over all four features (f3=200, f2=50, f1=10, f0).
      cfg(6'd0,  mk(1'b0, 2'd2, 8'd50,  6'd3, 6'd4,  2'd0));
      cfg(6'd3,  mk(1'b0, 2'd1, 8'd10,  6'd5, 6'd6,  2'd0));
      cfg(6'd5,  mk(1'b0, 2'd3, 8'd200, 6'd7, 6'd8,  2'd0));
      cfg(6'd7,  mk(1'b0, 2'd0, 8'd0,   6'd9, 6'd10, 2'd0));
      cfg(6'd9,  mk(1'b1, 2'd0, 8'd0,   6'd0, 6'd0,  2'd3));
      cfg(6'd10, mk(1'b1, 2'd0, 8'd0,   6'd0, 6'd0,  2'd2));
      send({8'd200, 8'd50, 8'd10, 8'd1}, 2, 4, 0, 6);
      wait_idle();
      send({8'd200, 8'd50, 8'd10, 8'd0}, 3, 4, 0, 6);
      wait_idle();

      // Async reset in cycle 2 of the depth-4 walk aborts it and clears the table.
      send({8'd200, 8'd50, 8'd10, 8'd1}, 2, 4, 0, 6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midwalk_rst_busy", int'(busy), 0);
      check("midwalk_rst_valid", int'(out_valid), 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send({8'd200, 8'd50, 8'd10, 8'd1}, 0, 0, 0, 2);
      wait_idle();
      repeat (2) @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
